parity_calc: RTL and testbench

- Bit-serial parity generator for one data word.
- A rising edge on start captures data_in. The word is then shifted out over WIDTH cycles while the set bits are XOR-accumulated.
- After the last shift, even_parity and odd_parity are registered and held. busy indicates an operation is in progress.
- data_in comes from an upstream stimulus or data source such as parity_stim. data_in need only be valid on the capture cycle.

---
 rtl/parity_calc.sv | 87 ++++++++
 tb/tb_parity_calc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/parity_calc.sv
// parity_calc: bit-serial parity of one WIDTH-bit word.
// A rising edge on start captures data_in. The word is then shifted out
// LSB first over WIDTH cycles while its bits are XOR-accumulated.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high reset
//   start       - operation request; only its rising edge is acted on
//   data_in     - word to check, sampled on the accepting edge only
//   even_parity - registered XOR of the captured bits
//   odd_parity  - registered complement of even_parity
//   busy        - high while a word is being shifted
module parity_calc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             even_parity,
   output logic             odd_parity,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic             acc;
   logic [CW-1:0]    count;
   logic             start_q;
   logic             start_rise;
   logic             fold;

   assign start_rise = start & ~start_q;

   // Parity including the bit being shifted out on this edge.
   assign fold = acc ^ shift_reg[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         even_parity <= 1'b0;
         odd_parity  <= 1'b1;
         shift_reg   <= '0;
         acc         <= 1'b0;
         count       <= '0;
         start_q     <= 1'b0;
      end else begin
         start_q <= start;
         unique case (state)
            IDLE: begin
               if (start_rise) begin
                  shift_reg <= data_in;
                  acc       <= 1'b0;
                  count     <= '0;
                  state     <= SHIFT;
                  busy      <= 1'b1;
               end
            end
            SHIFT: begin
               acc       <= fold;
               shift_reg <= shift_reg >> 1;
               count     <= count + CW'(1);
               // Rises seen here are dropped, even on the final edge.
               if (count == LAST) begin
                  even_parity <= fold;
                  odd_parity  <= ~fold;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_calc.sv
// tb_parity_calc: random and directed checks of parity_calc against a
// transaction-level model (popcount parity, WIDTH-edge latency).
module tb_parity_calc;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             even_parity;
   logic             odd_parity;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   bit               m_prev;
   int               rem;
   logic [WIDTH-1:0] m_word;
   bit               m_busy;
   bit               m_even;

   parity_calc #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .data_in     (data_in),
      .even_parity (even_parity),
      .odd_parity  (odd_parity),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock, update the model with the inputs seen at that
   // edge, then compare on the falling edge.
   task automatic tick();
      bit rise;
      @(posedge clk);
      if (reset) begin
         m_prev = 1'b0;
         rem    = 0;
         m_busy = 1'b0;
         m_even = 1'b0;
      end else begin
         rise   = start && !m_prev;
         m_prev = start;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               m_busy = 1'b0;
               m_even = ($countones(m_word) % 2) == 1;
            end
         end else if (rise) begin
            m_word = data_in;
            rem    = WIDTH;
            m_busy = 1'b1;
         end
      end
      @(negedge clk);
      check("busy", busy, m_busy);
      check("even", even_parity, m_even);
      check("odd", odd_parity, !m_even);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [WIDTH-1:0] w, input logic exp_even);
      start   = 1'b1;
      data_in = w;
      tick();
      check("accept_busy", busy, 1'b1);
      start = 1'b0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         data_in = WIDTH'($urandom);
         tick();
      end
      check("busy_before_done", busy, 1'b1);
      tick();
      check("word_busy", busy, 1'b0);
      check("word_even", even_parity, exp_even);
      check("word_odd", odd_parity, ~exp_even);
      ticks(2);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      data_in = '0;
      m_prev  = 1'b0;
      rem     = 0;
      m_busy  = 1'b0;
      m_even  = 1'b0;

      ticks(2);
      check("rst_busy", busy, 1'b0);
      check("rst_even", even_parity, 1'b0);
      check("rst_odd", odd_parity, 1'b1);
      reset = 1'b0;
      ticks(10);
      check("idle_busy", busy, 1'b0);
      check("idle_odd", odd_parity, 1'b1);

      send(8'h00, 1'b0);
      send(8'hFF, 1'b0);
      send(8'h01, 1'b1);
      send(8'hA7, 1'b1);

      start   = 1'b1;
      data_in = 8'h03;
      ticks(10);
      check("level1_even", even_parity, 1'b0);
      check("level1_busy", busy, 1'b0);
      start = 1'b0;
      ticks(10);
      check("level_gap_busy", busy, 1'b0);
      start   = 1'b1;
      data_in = 8'h07;
      ticks(10);
      check("level2_even", even_parity, 1'b1);
      start = 1'b0;
      ticks(3);

      start   = 1'b1;
      data_in = 8'h01;
      tick();
      start = 1'b0;
      ticks(3);
      start   = 1'b1;
      data_in = 8'h00;
      tick();
      start = 1'b0;
      ticks(3);
      check("busy_pulse_still_busy", busy, 1'b1);
      tick();
      check("busy_pulse_done", busy, 1'b0);
      check("busy_pulse_even", even_parity, 1'b1);
      ticks(10);
      check("busy_pulse_no_second", busy, 1'b0);

      start   = 1'b1;
      data_in = 8'h80;
      tick();
      start = 1'b0;
      ticks(2);
      data_in = 8'h00;
      ticks(WIDTH);
      check("midchange_even", even_parity, 1'b1);
      check("midchange_odd", odd_parity, 1'b0);

      start   = 1'b1;
      data_in = 8'h01;
      tick();
      ticks(4);
      reset = 1'b1;
      tick();
      check("abort_busy", busy, 1'b0);
      check("abort_even", even_parity, 1'b0);
      check("abort_odd", odd_parity, 1'b1);
      reset = 1'b0;
      tick();
      check("post_reset_accept", busy, 1'b1);
      start = 1'b0;
      ticks(WIDTH + 2);

      for (int i = 0; i < 4000; i++) begin
         reset   = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) start = ~start;
         data_in = WIDTH'($urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
